ramb_dp_asym_param: RTL and testbench

- Parametrised single-clock true-dual-port block RAM with independent port widths.
- Successor to the fixed-geometry 16Kb S9/S36-style primitives. Adds:
  - generic widths and depth
  - per-byte write enables
  - optional output pipeline register
  - a registered collision flag
- Used as the common storage macro for FIFOs, line buffers and width converters inside the same clock domain.

---
 rtl/ramb_dp_asym_param.sv | 149 ++++++++++++++
 tb/tb_ramb_dp_asym_param.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb_dp_asym_param.sv
// Single-clock true-dual-port byte-lane RAM with independent port widths, per-byte write
// enables, optional output register and a registered collision flag. INIT/SRVAL are {parity, data}.
module ramb_dp_asym_param #(
  parameter int    DATA_BITS    = 16384,
  parameter int    WIDTH_A      = 8,
  parameter int    WIDTH_B      = 32,
  parameter string WRITE_MODE_A = "WRITE_FIRST",
  parameter string WRITE_MODE_B = "WRITE_FIRST",
  parameter int    DO_REG_A     = 0,
  parameter int    DO_REG_B     = 0,
  parameter logic [WIDTH_A+WIDTH_A/8-1:0] INIT_A  = '0,
  parameter logic [WIDTH_B+WIDTH_B/8-1:0] INIT_B  = '0,
  parameter logic [WIDTH_A+WIDTH_A/8-1:0] SRVAL_A = '0,
  parameter logic [WIDTH_B+WIDTH_B/8-1:0] SRVAL_B = '0,
  localparam int AW_A = $clog2(DATA_BITS / WIDTH_A),
  localparam int AW_B = $clog2(DATA_BITS / WIDTH_B)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENA,
  input  logic [WIDTH_A/8-1:0] WEA,
  input  logic [AW_A-1:0]      ADDRA,
  input  logic [WIDTH_A-1:0]   DIA,
  input  logic [WIDTH_A/8-1:0] DIPA,
  input  logic                 SSRA,
  input  logic                 REGCEA,
  output logic [WIDTH_A-1:0]   DOA,
  output logic [WIDTH_A/8-1:0] DOPA,
  input  logic                 ENB,
  input  logic [WIDTH_B/8-1:0] WEB,
  input  logic [AW_B-1:0]      ADDRB,
  input  logic [WIDTH_B-1:0]   DIB,
  input  logic [WIDTH_B/8-1:0] DIPB,
  input  logic                 SSRB,
  input  logic                 REGCEB,
  output logic [WIDTH_B-1:0]   DOB,
  output logic [WIDTH_B/8-1:0] DOPB,
  output logic                 COLLISION
);

  localparam int NBYTES  = DATA_BITS / 8;
  localparam int BW      = $clog2(NBYTES);
  localparam int BA      = WIDTH_A / 8;
  localparam int BB      = WIDTH_B / 8;
  localparam int LA      = $clog2(BA);
  localparam int LB      = $clog2(BB);
  localparam int LM      = (LA > LB) ? LA : LB;
  localparam int MODE_WF = 0;
  localparam int MODE_RF = 1;
  localparam int MODE_A  = (WRITE_MODE_A == "READ_FIRST") ? 1 : (WRITE_MODE_A == "NO_CHANGE") ? 2 : 0;
  localparam int MODE_B  = (WRITE_MODE_B == "READ_FIRST") ? 1 : (WRITE_MODE_B == "NO_CHANGE") ? 2 : 0;

  // Each byte location holds {parity, data}; the array is never reset.
  logic [8:0] mem [NBYTES] = '{default: '0};

  logic [BW-1:0]         base_a, base_b;
  logic [WIDTH_A-1:0]    old_a_d, wf_a_d;
  logic [BA-1:0]         old_a_par, wf_a_par;
  logic [WIDTH_B-1:0]    old_b_d, wf_b_d;
  logic [BB-1:0]         old_b_par, wf_b_par;
  logic [WIDTH_A+BA-1:0] rd_a_p1, rd_a_p2;
  logic [WIDTH_B+BB-1:0] rd_b_p1, rd_b_p2;
  logic                  coll_p0;

  assign base_a = BW'(ADDRA) << LA;
  assign base_b = BW'(ADDRB) << LB;

  always_comb begin
    old_a_d   = '0;
    old_a_par = '0;
    wf_a_d    = '0;
    wf_a_par  = '0;
    for (int i = 0; i < BA; i++) begin
      old_a_d[8*i +: 8] = mem[base_a + BW'(i)][7:0];
      old_a_par[i]      = mem[base_a + BW'(i)][8];
      wf_a_d[8*i +: 8]  = WEA[i] ? DIA[8*i +: 8] : mem[base_a + BW'(i)][7:0];
      wf_a_par[i]       = WEA[i] ? DIPA[i] : mem[base_a + BW'(i)][8];
    end
  end

  always_comb begin
    old_b_d   = '0;
    old_b_par = '0;
    wf_b_d    = '0;
    wf_b_par  = '0;
    for (int i = 0; i < BB; i++) begin
      old_b_d[8*i +: 8] = mem[base_b + BW'(i)][7:0];
      old_b_par[i]      = mem[base_b + BW'(i)][8];
      wf_b_d[8*i +: 8]  = WEB[i] ? DIB[8*i +: 8] : mem[base_b + BW'(i)][7:0];
      wf_b_par[i]       = WEB[i] ? DIPB[i] : mem[base_b + BW'(i)][8];
    end
  end

  // Port A is applied last so it wins any byte both ports write in the same cycle.
  always_ff @(posedge CLK) begin
    if (ENB) begin
      for (int i = 0; i < BB; i++)
        if (WEB[i]) mem[base_b + BW'(i)] <= {DIPB[i], DIB[8*i +: 8]};
    end
    if (ENA) begin
      for (int i = 0; i < BA; i++)
        if (WEA[i]) mem[base_a + BW'(i)] <= {DIPA[i], DIA[8*i +: 8]};
    end
  end

  // Stage p1: read latch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_a_p1 <= INIT_A;
    end else if (ENA) begin
      if (SSRA && DO_REG_A == 0)                rd_a_p1 <= SRVAL_A;
      else if (MODE_A == MODE_WF)               rd_a_p1 <= {wf_a_par, wf_a_d};
      else if (MODE_A == MODE_RF || WEA == '0)  rd_a_p1 <= {old_a_par, old_a_d};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_b_p1 <= INIT_B;
    end else if (ENB) begin
      if (SSRB && DO_REG_B == 0)                rd_b_p1 <= SRVAL_B;
      else if (MODE_B == MODE_WF)               rd_b_p1 <= {wf_b_par, wf_b_d};
      else if (MODE_B == MODE_RF || WEB == '0)  rd_b_p1 <= {old_b_par, old_b_d};
    end
  end

  // Stage p2: optional output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         rd_a_p2 <= INIT_A;
    else if (REGCEA) rd_a_p2 <= SSRA ? SRVAL_A : rd_a_p1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         rd_b_p2 <= INIT_B;
    else if (REGCEB) rd_b_p2 <= SSRB ? SRVAL_B : rd_b_p1;
  end

  assign {DOPA, DOA} = (DO_REG_A != 0) ? rd_a_p2 : rd_a_p1;
  assign {DOPB, DOB} = (DO_REG_B != 0) ? rd_b_p2 : rd_b_p1;

  // Aligned power-of-two ranges overlap exactly when their bases agree above the wider span.
  assign coll_p0 = ENA && ENB && ((|WEA) || (|WEB)) && ((base_a >> LM) == (base_b >> LM));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) COLLISION <= 1'b0;
    else     COLLISION <= coll_p0;
  end

endmodule

// File: tb/tb_ramb_dp_asym_param.sv
// Bench for ramb_dp_asym_param: three instances (different modes/registers) share one stimulus
// stream and are compared against a byte-array reference model.
module tb_ramb_dp_asym_param;

  localparam int DB = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ENA = 1'b0, SSRA = 1'b0, REGCEA = 1'b0;
  logic [0:0]  WEA = '0, DIPA = '0;
  logic [6:0]  ADDRA = '0;
  logic [7:0]  DIA = '0;
  logic        ENB = 1'b0, SSRB = 1'b0, REGCEB = 1'b0;
  logic [3:0]  WEB = '0, DIPB = '0;
  logic [4:0]  ADDRB = '0;
  logic [31:0] DIB = '0;

  logic [7:0]  doa  [3];
  logic [0:0]  dopa [3];
  logic [31:0] dob  [3];
  logic [3:0]  dopb [3];
  logic        coll [3];

  int mode_a  [3] = '{0, 1, 2};
  int mode_b  [3] = '{0, 0, 2};
  int doreg_b [3] = '{0, 1, 0};
  logic [8:0]  init_a  [3] = '{9'h000, 9'h1A5, 9'h07E};
  logic [35:0] init_b  [3] = '{36'h0_00000000, 36'h3_CAFEF00D, 36'hF_01020304};
  logic [8:0]  srval_a [3] = '{9'h155, 9'h0C3, 9'h1E1};
  logic [35:0] srval_b [3] = '{36'h9_12345678, 36'h5_DEADBEEF, 36'h6_0BADF00D};

  logic [8:0]  rmem [128];
  logic [8:0]  lat_a [3];
  logic [35:0] lat_b [3];
  logic [35:0] reg_b [3];
  logic        rcoll;
  logic [7:0]  exp2 [4] = '{8'hDD, 8'h00, 8'hBB, 8'h00};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  ramb_dp_asym_param #(.DATA_BITS(DB), .WIDTH_A(8), .WIDTH_B(32),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"), .DO_REG_A(0), .DO_REG_B(0),
    .INIT_A(9'h000), .INIT_B(36'h0_00000000), .SRVAL_A(9'h155), .SRVAL_B(36'h9_12345678)
  ) u0 (.CLK(CLK), .RST(RST), .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DIPA(DIPA),
    .SSRA(SSRA), .REGCEA(REGCEA), .DOA(doa[0]), .DOPA(dopa[0]), .ENB(ENB), .WEB(WEB),
    .ADDRB(ADDRB), .DIB(DIB), .DIPB(DIPB), .SSRB(SSRB), .REGCEB(REGCEB), .DOB(dob[0]),
    .DOPB(dopb[0]), .COLLISION(coll[0]));

  ramb_dp_asym_param #(.DATA_BITS(DB), .WIDTH_A(8), .WIDTH_B(32),
    .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST"), .DO_REG_A(0), .DO_REG_B(1),
    .INIT_A(9'h1A5), .INIT_B(36'h3_CAFEF00D), .SRVAL_A(9'h0C3), .SRVAL_B(36'h5_DEADBEEF)
  ) u1 (.CLK(CLK), .RST(RST), .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DIPA(DIPA),
    .SSRA(SSRA), .REGCEA(REGCEA), .DOA(doa[1]), .DOPA(dopa[1]), .ENB(ENB), .WEB(WEB),
    .ADDRB(ADDRB), .DIB(DIB), .DIPB(DIPB), .SSRB(SSRB), .REGCEB(REGCEB), .DOB(dob[1]),
    .DOPB(dopb[1]), .COLLISION(coll[1]));

  ramb_dp_asym_param #(.DATA_BITS(DB), .WIDTH_A(8), .WIDTH_B(32),
    .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("NO_CHANGE"), .DO_REG_A(0), .DO_REG_B(0),
    .INIT_A(9'h07E), .INIT_B(36'hF_01020304), .SRVAL_A(9'h1E1), .SRVAL_B(36'h6_0BADF00D)
  ) u2 (.CLK(CLK), .RST(RST), .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DIPA(DIPA),
    .SSRA(SSRA), .REGCEA(REGCEA), .DOA(doa[2]), .DOPA(dopa[2]), .ENB(ENB), .WEB(WEB),
    .ADDRB(ADDRB), .DIB(DIB), .DIPB(DIPB), .SSRB(SSRB), .REGCEB(REGCEB), .DOB(dob[2]),
    .DOPB(dopb[2]), .COLLISION(coll[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 32-bit word at a B address, returned as {parity[3:0], data[31:0]}.
  function automatic logic [35:0] rd_b(input int addr);
    logic [35:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[8*j +: 8] = rmem[addr*4 + j][7:0];
      w[32 + j]   = rmem[addr*4 + j][8];
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      lat_a[k] = init_a[k];
      lat_b[k] = init_b[k];
      reg_b[k] = init_b[k];
    end
    rcoll = 1'b0;
  endtask

  // Advance the model over one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [8:0]  old_a, wa;
    logic [35:0] old_b, wf_b;
    old_a = rmem[ADDRA];
    old_b = rd_b(int'(ADDRB));
    wa    = {DIPA[0], DIA};
    wf_b  = old_b;
    for (int j = 0; j < 4; j++)
      if (WEB[j]) begin
        wf_b[8*j +: 8] = DIB[8*j +: 8];
        wf_b[32 + j]   = DIPB[j];
      end
    if (RST) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ENA) begin
          if (SSRA)                  lat_a[k] = srval_a[k];
          else if (mode_a[k] == 0)   lat_a[k] = WEA[0] ? wa : old_a;
          else if (mode_a[k] == 1)   lat_a[k] = old_a;
          else if (WEA == 1'b0)      lat_a[k] = old_a;
        end
        if (doreg_b[k] != 0 && REGCEB) reg_b[k] = SSRB ? srval_b[k] : lat_b[k];
        if (ENB) begin
          if (SSRB && doreg_b[k] == 0) lat_b[k] = srval_b[k];
          else if (mode_b[k] == 0)     lat_b[k] = wf_b;
          else if (mode_b[k] == 1)     lat_b[k] = old_b;
          else if (WEB == 4'b0)        lat_b[k] = old_b;
        end
      end
      rcoll = ENA && ENB && (WEA != 1'b0 || WEB != 4'b0) && (int'(ADDRA) / 4 == int'(ADDRB));
    end
    if (ENB)
      for (int j = 0; j < 4; j++)
        if (WEB[j]) rmem[int'(ADDRB)*4 + j] = {DIPB[j], DIB[8*j +: 8]};
    if (ENA && WEA[0]) rmem[ADDRA] = wa;
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_porta", k), 64'({dopa[k], doa[k]}), 64'(lat_a[k]));
      chk($sformatf("u%0d_portb", k), 64'({dopb[k], dob[k]}),
          64'((doreg_b[k] != 0) ? reg_b[k] : lat_b[k]));
      chk($sformatf("u%0d_collision", k), 64'(coll[k]), 64'(rcoll));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic async_reset_pulse();
    #2 RST = 1'b1;
    model_reset();
    #1 check_all();
  endtask

  task automatic idle();
    ENA = 1'b0; WEA = '0; SSRA = 1'b0; REGCEA = 1'b0;
    ENB = 1'b0; WEB = '0; SSRB = 1'b0; REGCEB = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) rmem[i] = '0;
    model_reset();

    // reset state
    #2 RST = 1'b1;
    #1 check_all();
    chk("rst_u1_doa", 64'(doa[1]), 64'h A5);
    tick();
    RST = 1'b0;

    // A writes bytes 0..3, B reads the packed word
    for (int i = 0; i < 4; i++) begin
      ENA = 1'b1; WEA = 1'b1; ADDRA = 7'(i); DIA = 8'((i + 1) * 8'h11); DIPA = '0;
      tick();
    end
    idle();
    ENB = 1'b1; ADDRB = 5'd0;
    tick();
    chk("pack_dob", 64'(dob[0]), 64'h4433_2211);

    // B partial write on lanes 0 and 2, A reads bytes 4..7
    idle();
    ENB = 1'b1; WEB = 4'b0101; ADDRB = 5'd1; DIB = 32'hAABB_CCDD; DIPB = '0;
    tick();
    idle();
    for (int i = 4; i < 8; i++) begin
      ENA = 1'b1; ADDRA = 7'(i);
      tick();
      chk($sformatf("lane_doa%0d", i), 64'(doa[0]), 64'(exp2[i-4]));
    end

    // write/write collision, then read/write collision
    ENA = 1'b1; WEA = 1'b1; ADDRA = 7'd5; DIA = 8'h5A;
    ENB = 1'b1; WEB = 4'b0010; ADDRB = 5'd1; DIB = 32'h0000_7700;
    tick();
    chk("ww_collision", 64'(coll[0]), 64'd1);
    ENA = 1'b1; WEA = 1'b1; ADDRA = 7'd6; DIA = 8'h66;
    ENB = 1'b1; WEB = 4'b0000; ADDRB = 5'd1;
    tick();
    chk("rw_old_byte6", 64'(dob[0][23:16]), 64'h BB);
    chk("ww_winner_byte5", 64'(dob[0][15:8]), 64'h 5A);
    chk("rw_collision", 64'(coll[0]), 64'd1);
    idle();
    tick();
    chk("collision_drop", 64'(coll[0]), 64'd0);
    ENA = 1'b1; ADDRA = 7'd5;
    tick();
    chk("byte5_readback", 64'(doa[0]), 64'h 5A);

    // read-during-write modes
    ENA = 1'b1; WEA = 1'b1; ADDRA = 7'd8; DIA = 8'h10;
    tick();
    WEA = 1'b0; ADDRA = 7'd0;
    tick();
    WEA = 1'b1; ADDRA = 7'd8; DIA = 8'h99;
    tick();
    chk("mode_write_first", 64'(doa[0]), 64'h 99);
    chk("mode_read_first", 64'(doa[1]), 64'h 10);
    chk("mode_no_change", 64'(doa[2]), 64'h 11);

    // output register on B of u1
    idle();
    ENB = 1'b1; ADDRB = 5'd0;
    tick();
    ENB = 1'b0; REGCEB = 1'b1;
    tick();
    chk("doreg_two_cycles", 64'(dob[1]), 64'h4433_2211);
    ENB = 1'b1; ADDRB = 5'd1; REGCEB = 1'b0;
    tick();
    chk("doreg_hold1", 64'(dob[1]), 64'h4433_2211);
    ENB = 1'b0;
    tick();
    chk("doreg_hold2", 64'(dob[1]), 64'h4433_2211);
    REGCEB = 1'b1;
    tick();
    chk("doreg_update", 64'(dob[1]), 64'h0066_5ADD);
    SSRB = 1'b1;
    tick();
    chk("doreg_ssr", 64'({dopb[1], dob[1]}), 64'h5_DEAD_BEEF);

    // asynchronous reset mid-burst; a write at a reset edge still lands
    idle();
    ENA = 1'b1; WEA = 1'b1; ADDRA = 7'd9; DIA = 8'h3C;
    ENB = 1'b1; ADDRB = 5'd2;
    tick();
    chk("burst_collision", 64'(coll[0]), 64'd1);
    async_reset_pulse();
    chk("rst_collision", 64'(coll[0]), 64'd0);
    chk("rst_u1_dob", 64'({dopb[1], dob[1]}), 64'h3_CAFE_F00D);
    ADDRA = 7'd10; DIA = 8'hC3; ENB = 1'b0;
    tick();
    RST = 1'b0;
    idle();
    ENA = 1'b1; ADDRA = 7'd10; ENB = 1'b1; ADDRB = 5'd0;
    tick();
    chk("rst_edge_write", 64'(doa[0]), 64'h C3);
    chk("post_rst_dob", 64'(dob[0]), 64'h4433_2211);
    ADDRA = 7'd9;
    tick();
    chk("pre_rst_write", 64'(doa[0]), 64'h 3C);

    // randomized traffic over a small window so collisions are frequent
    for (int n = 0; n < 600; n++) begin
      ENA    = 1'($urandom_range(0, 1));
      WEA    = 1'($urandom_range(0, 1));
      ADDRA  = 7'($urandom_range(0, 15));
      DIA    = 8'($urandom);
      DIPA   = 1'($urandom);
      SSRA   = ($urandom_range(0, 7) == 0);
      REGCEA = 1'($urandom_range(0, 1));
      ENB    = 1'($urandom_range(0, 1));
      WEB    = 4'($urandom);
      ADDRB  = 5'($urandom_range(0, 3));
      DIB    = $urandom;
      DIPB   = 4'($urandom);
      SSRB   = ($urandom_range(0, 7) == 0);
      REGCEB = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        async_reset_pulse();
        #2 RST = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
